int_rs: RTL and testbench
=========================

// Module: int_rs
// PURPOSE
//  Integer reservation station: buffers renamed ALU uops from dispatch, captures operand values
//  from the CDB, and issues the oldest ready uop into the registered int_rs_reg/int_rs_reg_valid
//  pair feeding fu_alu. It is the producer of that issue interface and a listener of the CDB
//  that fu_alu drives.
// PARAMETERS
//  INT_RS_DEPTH  8   number of entries (power of two, >=2)
// PORTS
//  clk               in   1             clock; all state updates on posedge
//  rst               in   1             asynchronous, active-low reset
//  flush             in   1             sync mispredict flush; kill all entries and the issue reg
//  dispatch_valid    in   1             dispatch offers a uop
//  dispatch_ready    out  1             at least one free entry
//  dispatch_uop      in   int_rs_uop_t  rob_id, rd_arch, rd_phy, rs{1,2}_phy, rs{1,2}_rdy, rs{1,2}_value, op1_sel, op2_sel, fu_opcode, imm_packed, pc
//  cdb_valid         in   1             CDB broadcast this cycle
//  cdb_rd_phy        in   PRF_IDX_W     broadcast tag
//  cdb_rd_value      in   32            broadcast value
//  int_rs_reg        out  int_rs_reg_t  issued uop to fu_alu
//  int_rs_reg_valid  out  1             issue register holds a uop
//  int_rs_reg_ready  in   1             fu_alu accepts int_rs_reg this cycle
// BEHAVIOUR
//  - Reset (rst=0, async): all entry valid bits, age state, int_rs_reg_valid = 0; int_rs_reg = '0;
//    dispatch_ready = 1 after release.
//  - Allocation: on dispatch_valid && dispatch_ready && !flush, write the lowest-index free entry.
//    The uop is age-youngest and visible to select the next cycle.
//  - dispatch_ready = |~entry_valid from current flops only. A slot freed by an issue this cycle
//    is NOT reusable until the next cycle.
//  - Dispatch bypass: if cdb_valid and cdb_rd_phy == rsN_phy for a not-ready operand in the same
//    cycle, store cdb_rd_value and set rsN_rdy.
//  - Wakeup: every valid entry with a not-ready operand whose tag equals cdb_rd_phy (cdb_valid=1)
//    latches cdb_rd_value and sets rdy at the edge. One tag can wake multiple entries and both
//    operands of one entry.
//  - Operand readiness: an operand counts as ready if op1_sel!=OP1_RS1 or op2_sel!=OP2_RS2.
//    Its rdy bit is ignored.
//  - Request: entry_valid && both operands ready (post-flop values; no same-cycle wake-to-issue).
//  - Select: the oldest requesting entry, via the age matrix.
//  - Issue-reg advance: issue_en = ~int_rs_reg_valid | int_rs_reg_ready.
//    - If issue_en and a request exists: load int_rs_reg from the selected entry, set valid,
//      and free the entry.
//    - If issue_en and no request exists: clear valid.
//    - If issue_en=0: hold int_rs_reg and its valid unchanged; no entry freed.
//  - Latency: dispatch at edge k with ready operands gives int_rs_reg_valid=1 after edge k+1.
//    A CDB wakeup at edge k gives earliest issue after edge k+1.
//  - Throughput: 1 uop/cycle when int_rs_reg_ready=1.
//  - Full: all entries valid gives dispatch_ready=0. Dispatch with dispatch_ready=0 is ignored.
//  - Flush wins over dispatch, wakeup and issue in the same cycle. Next cycle: all entries
//    invalid, int_rs_reg_valid=0.
//  - int_rs_reg fields other than valid are don't-care when valid=0. No X may leak to valid.
// STRUCTURE
//  - Package int_rs_types holds:
//    - int_rs_uop_t and int_rs_reg_t (the existing issue struct)
//    - INT_RS_DEPTH default and INT_RS_IDX_W = $clog2(INT_RS_DEPTH)
//  - Uses cpu_params (PRF_IDX_W, ROB_IDX_W) and uop_types (op1/op2 sel, fu_opcode enums).
//  - Sub-module rs_age_matrix #(DEPTH):
//    - NxN older-than bits; alloc sets the row/column for the new entry; free clears its row.
//    - Outputs a one-hot oldest grant from a request vector.
//  - Top level holds the entry array, free-slot priority encoder, CDB compare and issue register.
// TESTING
//  - Reset then dispatch ADD (rs1=5, rs2=7, both rdy) at cycle 1, ready=1 -> int_rs_reg_valid
//    after edge 2, fu_opcode=ALU_ADD, rs1_value=5, rs2_value=7. The entry is freed.
//  - Dispatch SUB with rs2_phy=12 not ready; CDB rd_phy=12, value 0x10 three cycles later ->
//    issue the cycle after the broadcast with rs2_value=0x10.
//    Repeat with the CDB in the dispatch cycle (bypass) -> same result.
//  - Fill 8 entries, none ready -> dispatch_ready=0 and a 9th dispatch is dropped.
//    A single CDB tag wakes entries 2 and 6 (6 older) -> 6 issues first, then 2.
//  - Hold int_rs_reg_ready=0 for 4 cycles with 3 ready entries -> int_rs_reg stable and no entry
//    freed. On release, the three issue on consecutive cycles, oldest first.
//  - Flush in the same cycle as a dispatch, a CDB wakeup and a pending issue -> next cycle
//    int_rs_reg_valid=0, dispatch_ready=1, and no later issue of the flushed uops.
//  - Assert rst low mid-stream (asynchronously, between edges) -> int_rs_reg_valid drops
//    immediately and all entries are empty after release.

Source files
------------

// File: rtl/int_rs_pkg.sv
// Shared parameters, uop encodings and reservation-station bundle types
// for the integer issue path.
package cpu_params;
  localparam int PRF_IDX_W  = 6;
  localparam int ROB_IDX_W  = 5;
  localparam int ARCH_IDX_W = 5;
endpackage

package uop_types;
  typedef enum logic [1:0] {
    OP1_RS1,
    OP1_PC,
    OP1_ZERO
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_RS2,
    OP2_IMM,
    OP2_FOUR
  } op2_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_LUI
  } fu_opcode_e;
endpackage

package int_rs_types;
  import cpu_params::*;
  import uop_types::*;

  localparam int INT_RS_DEPTH = 8;
  localparam int INT_RS_IDX_W = $clog2(INT_RS_DEPTH);

  typedef struct packed {
    logic [ROB_IDX_W-1:0]  rob_id;
    logic [ARCH_IDX_W-1:0] rd_arch;
    logic [PRF_IDX_W-1:0]  rd_phy;
    logic [PRF_IDX_W-1:0]  rs1_phy;
    logic [PRF_IDX_W-1:0]  rs2_phy;
    logic                  rs1_rdy;
    logic                  rs2_rdy;
    logic [31:0]           rs1_value;
    logic [31:0]           rs2_value;
    op1_sel_e              op1_sel;
    op2_sel_e              op2_sel;
    fu_opcode_e            fu_opcode;
    logic [31:0]           imm_packed;
    logic [31:0]           pc;
  } int_rs_uop_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0]  rob_id;
    logic [ARCH_IDX_W-1:0] rd_arch;
    logic [PRF_IDX_W-1:0]  rd_phy;
    logic [31:0]           rs1_value;
    logic [31:0]           rs2_value;
    op1_sel_e              op1_sel;
    op2_sel_e              op2_sel;
    fu_opcode_e            fu_opcode;
    logic [31:0]           imm_packed;
    logic [31:0]           pc;
  } int_rs_reg_t;
endpackage

// File: rtl/int_rs_if.sv
// Dispatch, CDB and issue-register bundle around the integer RS.
// master = surrounding pipeline, slave = reservation station.
interface int_rs_if;
  import cpu_params::*;
  import int_rs_types::*;

  logic                 dispatch_valid;
  logic                 dispatch_ready;
  int_rs_uop_t          dispatch_uop;
  logic                 cdb_valid;
  logic [PRF_IDX_W-1:0] cdb_rd_phy;
  logic [31:0]          cdb_rd_value;
  int_rs_reg_t          int_rs_reg;
  logic                 int_rs_reg_valid;
  logic                 int_rs_reg_ready;

  modport master (
    output dispatch_valid,
    output dispatch_uop,
    output cdb_valid,
    output cdb_rd_phy,
    output cdb_rd_value,
    output int_rs_reg_ready,
    input  dispatch_ready,
    input  int_rs_reg,
    input  int_rs_reg_valid
  );

  modport slave (
    input  dispatch_valid,
    input  dispatch_uop,
    input  cdb_valid,
    input  cdb_rd_phy,
    input  cdb_rd_value,
    input  int_rs_reg_ready,
    output dispatch_ready,
    output int_rs_reg,
    output int_rs_reg_valid
  );
endinterface

// File: rtl/rs_age_matrix.sv
// Age matrix: older_q[i][j] set means entry i was allocated before j.
// Grants the single requester that no other requester is older than.
module rs_age_matrix #(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic             free,
  input  logic [IDX_W-1:0] free_idx,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] gnt
);
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] blocked;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        older_q[i] <= '0;
    end else begin
      // new entry: everyone is older, it is older than nobody
      if (alloc) begin
        for (int i = 0; i < DEPTH; i++)
          older_q[i][alloc_idx] <= 1'b1;
        older_q[alloc_idx] <= '0;
      end
      if (free)
        older_q[free_idx] <= '0;
    end
  end

  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        blocked[i] = blocked[i] | (req[j] & older_q[j][i]);
  end

  assign gnt = req & ~blocked;
endmodule

// File: rtl/int_rs.sv
// Integer reservation station: entry array, CDB wakeup and
// oldest-first select into the registered issue slot for fu_alu.
module int_rs
  import cpu_params::*;
  import uop_types::*;
  import int_rs_types::int_rs_uop_t;
  import int_rs_types::int_rs_reg_t;
#(
  parameter int INT_RS_DEPTH = int_rs_types::INT_RS_DEPTH
) (
  input logic     clk,
  input logic     rst,
  input logic     flush,
  int_rs_if.slave bus
);
  localparam int IDX_W = $clog2(INT_RS_DEPTH);

  int_rs_uop_t             uop_q [INT_RS_DEPTH];
  logic [INT_RS_DEPTH-1:0] valid_q;
  logic [INT_RS_DEPTH-1:0] rs1_ok;
  logic [INT_RS_DEPTH-1:0] rs2_ok;
  logic [INT_RS_DEPTH-1:0] req;
  logic [INT_RS_DEPTH-1:0] gnt;
  logic [IDX_W-1:0]        free_idx;
  logic [IDX_W-1:0]        sel_idx;
  logic                    alloc;
  logic                    any_req;
  logic                    issue_en;
  logic                    issue;
  int_rs_uop_t             new_uop;
  int_rs_reg_t             reg_q;
  logic                    reg_valid_q;

  assign bus.dispatch_ready   = |(~valid_q);
  assign bus.int_rs_reg       = reg_q;
  assign bus.int_rs_reg_valid = reg_valid_q;

  assign alloc    = bus.dispatch_valid
                  & bus.dispatch_ready
                  & ~flush;
  assign any_req  = |req;
  assign issue_en = ~reg_valid_q | bus.int_rs_reg_ready;
  assign issue    = issue_en & any_req & ~flush;

  always_comb begin
    free_idx = '0;
    for (int i = INT_RS_DEPTH - 1; i >= 0; i--)
      if (!valid_q[i])
        free_idx = IDX_W'(i);
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < INT_RS_DEPTH; i++)
      if (gnt[i])
        sel_idx = sel_idx | IDX_W'(i);
  end

  // non-register operands never wait on a tag
  always_comb begin
    rs1_ok = '0;
    rs2_ok = '0;
    for (int i = 0; i < INT_RS_DEPTH; i++) begin
      rs1_ok[i] = (uop_q[i].op1_sel != OP1_RS1)
                | uop_q[i].rs1_rdy;
      rs2_ok[i] = (uop_q[i].op2_sel != OP2_RS2)
                | uop_q[i].rs2_rdy;
    end
  end

  assign req = valid_q & rs1_ok & rs2_ok;

  always_comb begin
    new_uop = bus.dispatch_uop;
    if (bus.cdb_valid) begin
      if (!new_uop.rs1_rdy &&
          new_uop.rs1_phy == bus.cdb_rd_phy) begin
        new_uop.rs1_rdy   = 1'b1;
        new_uop.rs1_value = bus.cdb_rd_value;
      end
      if (!new_uop.rs2_rdy &&
          new_uop.rs2_phy == bus.cdb_rd_phy) begin
        new_uop.rs2_rdy   = 1'b1;
        new_uop.rs2_value = bus.cdb_rd_value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < INT_RS_DEPTH; i++)
        uop_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < INT_RS_DEPTH; i++) begin
        if (bus.cdb_valid && valid_q[i]) begin
          if (!uop_q[i].rs1_rdy &&
              uop_q[i].rs1_phy == bus.cdb_rd_phy) begin
            uop_q[i].rs1_rdy   <= 1'b1;
            uop_q[i].rs1_value <= bus.cdb_rd_value;
          end
          if (!uop_q[i].rs2_rdy &&
              uop_q[i].rs2_phy == bus.cdb_rd_phy) begin
            uop_q[i].rs2_rdy   <= 1'b1;
            uop_q[i].rs2_value <= bus.cdb_rd_value;
          end
        end
        if (issue && gnt[i])
          valid_q[i] <= 1'b0;
        if (alloc && free_idx == IDX_W'(i)) begin
          valid_q[i] <= 1'b1;
          uop_q[i]   <= new_uop;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_q       <= '0;
      reg_valid_q <= 1'b0;
    end else if (flush) begin
      reg_valid_q <= 1'b0;
    end else if (issue_en) begin
      reg_valid_q <= any_req;
      if (any_req)
        reg_q <= '{
          rob_id:     uop_q[sel_idx].rob_id,
          rd_arch:    uop_q[sel_idx].rd_arch,
          rd_phy:     uop_q[sel_idx].rd_phy,
          rs1_value:  uop_q[sel_idx].rs1_value,
          rs2_value:  uop_q[sel_idx].rs2_value,
          op1_sel:    uop_q[sel_idx].op1_sel,
          op2_sel:    uop_q[sel_idx].op2_sel,
          fu_opcode:  uop_q[sel_idx].fu_opcode,
          imm_packed: uop_q[sel_idx].imm_packed,
          pc:         uop_q[sel_idx].pc
        };
    end
  end

  rs_age_matrix #(
    .DEPTH (INT_RS_DEPTH)
  ) u_age (
    .clk       (clk),
    .rst       (rst),
    .alloc     (alloc),
    .alloc_idx (free_idx),
    .free      (issue),
    .free_idx  (sel_idx),
    .req       (req),
    .gnt       (gnt)
  );
endmodule

// File: tb/tb_int_rs.sv
// Bench for int_rs: directed scenarios plus random traffic checked
// against a slot/sequence-number model of the reservation station.
module tb_int_rs;
  import cpu_params::*;
  import uop_types::*;
  import int_rs_types::*;

  localparam int N = INT_RS_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  int_rs_if bus ();

  int_rs dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int_rs_uop_t m_uop [N];
  bit          m_val [N];
  int          m_seq [N];
  int          next_seq;
  int_rs_reg_t m_reg;
  bit          m_rv;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk_bit(string tag, logic obs, logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic chk_word(string tag, logic [31:0] obs,
                          logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reg(string tag, int_rs_reg_t obs,
                         int_rs_reg_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic bit ops_ready(int_rs_uop_t u);
    return (u.op1_sel != OP1_RS1 || u.rs1_rdy) &&
           (u.op2_sel != OP2_RS2 || u.rs2_rdy);
  endfunction

  function automatic int_rs_reg_t exp_reg(int_rs_uop_t u);
    int_rs_reg_t r;
    r.rob_id     = u.rob_id;
    r.rd_arch    = u.rd_arch;
    r.rd_phy     = u.rd_phy;
    r.rs1_value  = u.rs1_value;
    r.rs2_value  = u.rs2_value;
    r.op1_sel    = u.op1_sel;
    r.op2_sel    = u.op2_sel;
    r.fu_opcode  = u.fu_opcode;
    r.imm_packed = u.imm_packed;
    r.pc         = u.pc;
    return r;
  endfunction

  function automatic int_rs_uop_t mk(
    int rob, fu_opcode_e op,
    int p1, bit r1, logic [31:0] v1,
    int p2, bit r2, logic [31:0] v2);
    int_rs_uop_t u;
    u = '0;
    u.rob_id     = ROB_IDX_W'(rob);
    u.rd_arch    = ARCH_IDX_W'(rob);
    u.rd_phy     = PRF_IDX_W'(rob + 32);
    u.rs1_phy    = PRF_IDX_W'(p1);
    u.rs1_rdy    = r1;
    u.rs1_value  = v1;
    u.rs2_phy    = PRF_IDX_W'(p2);
    u.rs2_rdy    = r2;
    u.rs2_value  = v2;
    u.op1_sel    = OP1_RS1;
    u.op2_sel    = OP2_RS2;
    u.fu_opcode  = op;
    u.imm_packed = 32'(rob * 3);
    u.pc         = 32'h1000 + 32'(rob * 4);
    return u;
  endfunction

  function automatic int_rs_uop_t rnd_uop();
    int_rs_uop_t u;
    u = mk(int'($urandom_range(0, 31)),
           fu_opcode_e'($urandom_range(0, 10)),
           int'($urandom_range(0, 7)), 1'($urandom),
           $urandom,
           int'($urandom_range(0, 7)), 1'($urandom),
           $urandom);
    if ($urandom_range(0, 7) == 0)
      u.op1_sel = op1_sel_e'($urandom_range(1, 2));
    if ($urandom_range(0, 7) == 0)
      u.op2_sel = op2_sel_e'($urandom_range(1, 2));
    u.imm_packed = $urandom;
    return u;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_val[i] = 0;
    m_rv = 0;
    m_reg = '0;
    next_seq = 0;
  endtask

  function automatic bit m_has_free();
    for (int i = 0; i < N; i++)
      if (!m_val[i]) return 1;
    return 0;
  endfunction

  task automatic idle();
    bus.dispatch_valid   = 1'b0;
    bus.dispatch_uop     = '0;
    bus.cdb_valid        = 1'b0;
    bus.cdb_rd_phy       = '0;
    bus.cdb_rd_value     = '0;
    bus.int_rs_reg_ready = 1'b1;
    flush                = 1'b0;
  endtask

  task automatic disp(int_rs_uop_t u);
    bus.dispatch_valid = 1'b1;
    bus.dispatch_uop   = u;
  endtask

  task automatic cdb(int tag, logic [31:0] v);
    bus.cdb_valid    = 1'b1;
    bus.cdb_rd_phy   = PRF_IDX_W'(tag);
    bus.cdb_rd_value = v;
  endtask

  // apply one clock edge to the model and DUT, then compare
  task automatic step();
    int best;
    int fslot;
    bit ien;
    int_rs_uop_t u;
    if (flush) begin
      for (int i = 0; i < N; i++) m_val[i] = 0;
      m_rv = 0;
    end else begin
      ien = !m_rv || bus.int_rs_reg_ready;
      best = -1;
      fslot = -1;
      for (int i = 0; i < N; i++)
        if (m_val[i] && ops_ready(m_uop[i]) &&
            (best < 0 || m_seq[i] < m_seq[best]))
          best = i;
      for (int i = N - 1; i >= 0; i--)
        if (!m_val[i]) fslot = i;
      if (ien) begin
        m_rv = (best >= 0);
        if (best >= 0) begin
          m_reg = exp_reg(m_uop[best]);
          m_val[best] = 0;
        end
      end
      if (bus.cdb_valid)
        for (int i = 0; i < N; i++) if (m_val[i]) begin
          if (!m_uop[i].rs1_rdy &&
              m_uop[i].rs1_phy == bus.cdb_rd_phy) begin
            m_uop[i].rs1_rdy = 1;
            m_uop[i].rs1_value = bus.cdb_rd_value;
          end
          if (!m_uop[i].rs2_rdy &&
              m_uop[i].rs2_phy == bus.cdb_rd_phy) begin
            m_uop[i].rs2_rdy = 1;
            m_uop[i].rs2_value = bus.cdb_rd_value;
          end
        end
      if (bus.dispatch_valid && fslot >= 0) begin
        u = bus.dispatch_uop;
        if (bus.cdb_valid) begin
          if (!u.rs1_rdy && u.rs1_phy == bus.cdb_rd_phy) begin
            u.rs1_rdy = 1;
            u.rs1_value = bus.cdb_rd_value;
          end
          if (!u.rs2_rdy && u.rs2_phy == bus.cdb_rd_phy) begin
            u.rs2_rdy = 1;
            u.rs2_value = bus.cdb_rd_value;
          end
        end
        m_uop[fslot] = u;
        m_val[fslot] = 1;
        m_seq[fslot] = next_seq++;
      end
    end
    @(posedge clk);
    #1;
    chk_bit("dispatch_ready", bus.dispatch_ready, m_has_free());
    chk_bit("reg_valid", bus.int_rs_reg_valid, m_rv);
    if (m_rv)
      chk_reg("int_rs_reg", bus.int_rs_reg, m_reg);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    model_reset();
    // reset state
    @(posedge clk);
    #1;
    chk_bit("rst_reg_valid", bus.int_rs_reg_valid, 1'b0);
    chk_reg("rst_reg", bus.int_rs_reg, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_bit("rst_dispatch_ready", bus.dispatch_ready, 1'b1);

    // ADD with both operands ready
    disp(mk(1, ALU_ADD, 1, 1, 5, 2, 1, 7));
    step();
    chk_bit("add_lat_edge1", bus.int_rs_reg_valid, 1'b0);
    idle();
    step();
    chk_bit("add_valid", bus.int_rs_reg_valid, 1'b1);
    chk_word("add_op", 32'(bus.int_rs_reg.fu_opcode),
             32'(ALU_ADD));
    chk_word("add_rs1", bus.int_rs_reg.rs1_value, 5);
    chk_word("add_rs2", bus.int_rs_reg.rs2_value, 7);
    step();

    // SUB waits on tag 12, broadcast three cycles later
    disp(mk(2, ALU_SUB, 3, 1, 9, 12, 0, 0));
    step();
    idle();
    step();
    step();
    cdb(12, 32'h10);
    step();
    idle();
    step();
    chk_bit("sub_valid", bus.int_rs_reg_valid, 1'b1);
    chk_word("sub_rs2", bus.int_rs_reg.rs2_value, 32'h10);
    step();

    // same, with the CDB in the dispatch cycle
    disp(mk(3, ALU_SUB, 3, 1, 9, 12, 0, 0));
    cdb(12, 32'h10);
    step();
    idle();
    step();
    chk_bit("byp_valid", bus.int_rs_reg_valid, 1'b1);
    chk_word("byp_rs2", bus.int_rs_reg.rs2_value, 32'h10);
    step();

    // fill all slots with waiting uops, then a dropped 9th
    for (int i = 0; i < N; i++) begin
      disp(mk(8 + i, ALU_OR, 20 + i, 0, 0, 1, 1, 1));
      step();
    end
    chk_bit("full_ready", bus.dispatch_ready, 1'b0);
    disp(mk(31, ALU_AND, 40, 1, 0, 1, 1, 1));
    step();
    idle();
    cdb(22, 32'h22);
    step();
    idle();
    step();
    chk_word("slot2_first", 32'(bus.int_rs_reg.rob_id), 10);
    step();
    disp(mk(30, ALU_XOR, 26, 0, 0, 1, 1, 1));
    step();
    idle();
    cdb(26, 32'h26);
    step();
    idle();
    step();
    chk_word("older6_first", 32'(bus.int_rs_reg.rob_id), 14);
    step();
    chk_word("then_slot2", 32'(bus.int_rs_reg.rob_id), 30);
    foreach (m_val[i]) begin
      cdb(20 + i, 32'(i));
      step();
    end
    idle();
    repeat (10) step();

    // back-pressure with three ready uops
    bus.int_rs_reg_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(mk(16 + i, ALU_SLL, 1, 1, i, 2, 1, i));
      step();
    end
    bus.dispatch_valid = 1'b0;
    repeat (4) step();
    chk_word("hold_rob", 32'(bus.int_rs_reg.rob_id), 16);
    bus.int_rs_reg_ready = 1'b1;
    repeat (4) step();

    // flush against dispatch, wakeup and pending issue
    disp(mk(20, ALU_ADD, 50, 0, 0, 1, 1, 1));
    step();
    disp(mk(21, ALU_ADD, 1, 1, 4, 1, 1, 4));
    step();
    disp(mk(22, ALU_ADD, 1, 1, 4, 1, 1, 4));
    cdb(50, 32'h50);
    flush = 1'b1;
    step();
    chk_bit("flush_valid", bus.int_rs_reg_valid, 1'b0);
    chk_bit("flush_ready", bus.dispatch_ready, 1'b1);
    idle();
    repeat (4) step();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 9) < 6) disp(rnd_uop());
      if ($urandom_range(0, 1) == 1)
        cdb(int'($urandom_range(0, 7)), $urandom);
      bus.int_rs_reg_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      step();
    end

    // asynchronous reset between edges
    idle();
    bus.int_rs_reg_ready = 1'b0;
    disp(mk(5, ALU_ADD, 1, 1, 1, 1, 1, 1));
    step();
    step();
    chk_bit("pre_arst_valid", bus.int_rs_reg_valid, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk_bit("arst_valid", bus.int_rs_reg_valid, 1'b0);
    chk_bit("arst_ready", bus.dispatch_ready, 1'b1);
    idle();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
